// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Iterative AES-128 encryptor; one round datapath reused for ten
//               rounds with on-the-fly key expansion, valid/ready on both ends.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int NR           = 10,
    parameter bit EARLY_ACCEPT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         flush,
    output logic         busy,
    output logic [3:0]   round_idx
);

    if (NR != 10) begin : g_nrCheck
        $error("aes_round_sequencer: only NR=10 (AES-128) is supported");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsmState_t;

    localparam logic [3:0] c_lastRound = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // S-box as inverse (x^254) followed by the affine map, avoiding a 256-entry table
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gfMul(x, x);
        x3   = gfMul(x2, x);
        x6   = gfMul(x3, x3);
        x12  = gfMul(x6, x6);
        x15  = gfMul(x12, x3);
        x30  = gfMul(x15, x15);
        x60  = gfMul(x30, x30);
        x120 = gfMul(x60, x60);
        x240 = gfMul(x120, x120);
        x252 = gfMul(x240, x12);
        inv  = gfMul(x252, x2);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = sbox(s[127-8*(4*((c+rw)%4)+rw) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] keyExpand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = w0 ^ t ^ {rc, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsmState_t    r_fsm, w_fsmNext;
    logic [127:0] r_state, w_stateNext;
    logic [127:0] r_rk, w_rkNext;
    logic [3:0]   r_rnd, w_rndNext;
    logic [7:0]   r_rcon, w_rconNext;
    logic [127:0] w_rkExp, w_subShift, w_mixed;
    logic         w_accept;

    assign w_rkExp    = keyExpand(r_rk, r_rcon);
    assign w_subShift = subShift(r_state);
    assign w_mixed    = mixColumns(w_subShift);

    // flush gates in_ready so a flushed input is never seen as transferred
    assign in_ready  = !rst && !flush &&
                       ((r_fsm == S_IDLE) || (EARLY_ACCEPT && (r_fsm == S_DONE) && out_ready));
    assign out_valid = !rst && (r_fsm == S_DONE);
    assign out_data  = out_valid ? r_state : 128'h0;
    assign busy      = !rst && (r_fsm != S_IDLE);
    assign round_idx = (!rst && (r_fsm == S_ROUND)) ? r_rnd : 4'd0;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rk    <= '0;
            r_rnd   <= 4'd0;
            r_rcon  <= 8'h01;
        end else begin
            r_fsm   <= w_fsmNext;
            r_state <= w_stateNext;
            r_rk    <= w_rkNext;
            r_rnd   <= w_rndNext;
            r_rcon  <= w_rconNext;
        end
    end

    always_comb begin
        w_fsmNext   = r_fsm;
        w_stateNext = r_state;
        w_rkNext    = r_rk;
        w_rndNext   = r_rnd;
        w_rconNext  = r_rcon;
        if (w_accept) begin
            w_stateNext = in_data ^ in_key;
            w_rkNext    = in_key;
            w_rndNext   = 4'd1;
            w_rconNext  = 8'h01;
            w_fsmNext   = S_ROUND;
        end else begin
            case (r_fsm)
                S_ROUND: begin
                    w_rkNext   = w_rkExp;
                    w_rconNext = xtime(r_rcon);
                    if (r_rnd == c_lastRound) begin
                        w_stateNext = w_subShift ^ w_rkExp;
                        w_rndNext   = 4'd0;
                        w_fsmNext   = S_DONE;
                    end else begin
                        w_stateNext = w_mixed ^ w_rkExp;
                        w_rndNext   = r_rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) w_fsmNext = S_IDLE;
                end
                default: w_fsmNext = r_fsm;
            endcase
        end
        if (flush) begin
            w_fsmNext = S_IDLE;
            w_rndNext = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_sequencer
// Description : Directed and randomised checks of aes_round_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         flush;
    logic         busy;
    logic [3:0]   round_idx;

    int nAsserts = 0;
    int nFail    = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] c_K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .EARLY_ACCEPT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .busy      (busy),
        .round_idx (round_idx)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // Table S-box from the multiply-by-3 / divide-by-3 generator walk
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] refEncrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc, tmp, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp   = tw[0];
                tw[0] = sb[tw[1]] ^ rc;
                tw[1] = sb[tw[2]];
                tw[2] = sb[tw[3]];
                tw[3] = sb[tmp];
                rc    = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBlock(input logic [127:0] key, input logic [127:0] pt);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("inReadyTimeout", 128'(in_ready), 128'd1);
        in_key   = key;
        in_data  = pt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_key   = ~key;
        in_data  = ~pt;
    endtask

    // Latency counted in edges since the accepting edge
    task automatic waitOut(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        if (!out_valid) check("outValidTimeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        logic [127:0] k, p;

        buildSbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '0; in_key = '0;
        step();
        step();
        check("rstInReady",  128'(in_ready),  128'd0);
        check("rstOutValid", 128'(out_valid), 128'd0);
        check("rstBusy",     128'(busy),      128'd0);
        check("rstRoundIdx", 128'(round_idx), 128'd0);
        check("rstOutData",  out_data,        128'd0);
        rst = 1'b0;
        #1;
        check("idleInReady", 128'(in_ready), 128'd1);
        check("idleBusy",    128'(busy),     128'd0);

        // FIPS-197 App.B with output backpressure
        sendBlock(c_K1, c_P1);
        waitOut(lat);
        check("v1Latency", 128'(lat), 128'd11);
        check("v1Data",    out_data,  c_C1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bpValid",   128'(out_valid), 128'd1);
            check("bpData",    out_data,        c_C1);
            check("bpInReady", 128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        #1;
        check("doneEarlyReady", 128'(in_ready), 128'd1);
        step();
        check("bpAfterValid", 128'(out_valid), 128'd0);
        check("bpAfterData",  out_data,        128'd0);
        check("bpAfterBusy",  128'(busy),      128'd0);

        // FIPS-197 C.1 with round index walk
        sendBlock(c_K2, c_P2);
        for (int r = 1; r <= 10; r++) begin
            check("roundIdx", 128'(round_idx), 128'(r));
            check("roundBusy", 128'(busy), 128'd1);
            step();
        end
        check("v2Valid", 128'(out_valid), 128'd1);
        check("v2Data",  out_data,        c_C2);
        step();
        check("v2Released", 128'(out_valid), 128'd0);

        // Back-to-back streaming
        in_key = c_K1; in_data = c_P1; in_valid = 1'b1;
        step();
        in_key = c_K2; in_data = c_P2;
        waitOut(lat);
        check("b2bLat1",    128'(lat),      128'd11);
        check("b2bData1",   out_data,       c_C1);
        check("b2bInReady", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0; in_data = '0; in_key = '0;
        waitOut(lat);
        check("b2bLat2",  128'(lat), 128'd11);
        check("b2bData2", out_data,  c_C2);
        step();
        check("b2bIdle", 128'(out_valid), 128'd0);

        // Flush in IDLE beats a simultaneous input
        in_key = c_K1; in_data = c_P1; in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flushIdleInReady", 128'(in_ready), 128'd0);
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flushIdleBusy", 128'(busy), 128'd0);

        // Flush at round 5, then C.1
        sendBlock(c_K1, c_P1);
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            step();
            n++;
        end
        check("flushReachR5", 128'(round_idx), 128'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flushBusy",  128'(busy),      128'd0);
        check("flushRound", 128'(round_idx), 128'd0);
        for (int i = 0; i < 12; i++) begin
            check("flushNoOut", 128'(out_valid), 128'd0);
            step();
        end
        sendBlock(c_K2, c_P2);
        waitOut(lat);
        check("postFlushLat",  128'(lat), 128'd11);
        check("postFlushData", out_data,  c_C2);
        step();

        // Reset mid-ROUND
        sendBlock(c_K1, c_P1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("midRstInReady",  128'(in_ready),  128'd0);
        check("midRstOutValid", 128'(out_valid), 128'd0);
        check("midRstBusy",     128'(busy),      128'd0);
        check("midRstRoundIdx", 128'(round_idx), 128'd0);
        check("midRstOutData",  out_data,        128'd0);
        step();
        rst = 1'b0;
        #1;
        check("postRstBusy",    128'(busy),     128'd0);
        check("postRstInReady", 128'(in_ready), 128'd1);
        sendBlock(c_K2, c_P2);
        waitOut(lat);
        check("postRstData", out_data, c_C2);
        step();

        // Random vectors against the reference model
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            sendBlock(k, p);
            waitOut(lat);
            check("random", out_data, refEncrypt(k, p));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
`default_nettype wire
